// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: records committed register writes (dest, data[12:0], pc[12:0])
// into a FIFO and shows them one at a time on the seven-segment display feed.
// Each entry is held for HOLD_CYCLES unfrozen cycles.
//
// Optional build macro: WB_TRACE_SKIP_R0_EN -- when defined, commits to r0 are
// ignored (not captured, never counted as drops).
//
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   WB_RegWrite     commit strobe from MEM/WB
//   WB_RegDest      destination register of the commit
//   WB_WriteData    value written (only [12:0] is kept)
//   WB_PC           PC of committing instruction (only [12:0] is kept)
//   Freeze          stalls both capture and display advance
//   NumberA/B       data[12:0] / pc[12:0] of the displayed entry
//   Dest_Out        destination of the displayed entry
//   Valid_Out       an entry is being shown
//   Overflow        sticky: a commit was dropped on a full FIFO
//   Count           FIFO occupancy, excluding the displayed entry
module wb_trace_buffer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   WB_RegWrite,
  input  logic [4:0]             WB_RegDest,
  input  logic [31:0]            WB_WriteData,
  input  logic [31:0]            WB_PC,
  input  logic                   Freeze,
  output logic [12:0]            NumberA,
  output logic [12:0]            NumberB,
  output logic [4:0]             Dest_Out,
  output logic                   Valid_Out,
  output logic                   Overflow,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned EW = 5 + 13 + 13;

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [HW-1:0]   r_hold;
  logic [12:0]     r_num_a;
  logic [12:0]     r_num_b;
  logic [4:0]      r_dest;
  logic            r_valid;
  logic            r_overflow;

  logic            w_commit;
  logic            w_nonempty;
  logic            w_full;
  logic            w_pop;
  logic            w_hold_dec;
  logic            w_push;
  logic            w_drop;
  logic [EW-1:0]   w_entry;
  logic            w_unused;

  // Upper data/PC bits are never displayed.
  assign w_unused = ^{WB_WriteData[31:13], WB_PC[31:13]};

  // Qualified commit: frozen commits vanish silently.
`ifdef WB_TRACE_SKIP_R0_EN
  assign w_commit = WB_RegWrite && !Freeze && (WB_RegDest != 5'd0);
`else
  assign w_commit = WB_RegWrite && !Freeze;
`endif

  assign w_nonempty = (r_count != CW'(0));
  assign w_full     = (r_count == CW'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push     = w_commit && (!w_full || w_pop);
  assign w_drop     = w_commit && w_full && !w_pop;
  assign w_entry    = {WB_RegDest, WB_WriteData[12:0], WB_PC[12:0]};

  // Display FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Display FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_nonempty && !Freeze) w_state_nxt = S_SHOW;
      S_SHOW:  if (!Freeze && (r_hold == HW'(0)) && !w_nonempty) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Display FSM control outputs: pop the head or count down the hold timer.
  always_comb begin
    w_pop      = 1'b0;
    w_hold_dec = 1'b0;
    case (r_state)
      S_IDLE: w_pop = w_nonempty && !Freeze;
      S_SHOW: begin
        if (!Freeze) begin
          if (r_hold != HW'(0)) w_hold_dec = 1'b1;
          else                  w_pop      = w_nonempty;
        end
      end
      default: ;
    endcase
  end

  // FIFO storage; contents are meaningless after reset, so not cleared.
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // Pointers, occupancy, hold timer, sticky overflow and display registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_hold     <= '0;
      r_num_a    <= '0;
      r_num_b    <= '0;
      r_dest     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        {r_dest, r_num_a, r_num_b} <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_hold   <= HW'(HOLD_CYCLES - 1);
      end else if (w_hold_dec) begin
        r_hold <= r_hold - HW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      r_valid <= (w_state_nxt == S_SHOW);
    end
  end

  assign NumberA   = r_num_a;
  assign NumberB   = r_num_b;
  assign Dest_Out  = r_dest;
  assign Valid_Out = r_valid;
  assign Overflow  = r_overflow;
  assign Count     = r_count;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer (DEPTH=4, HOLD_CYCLES=3): directed scenarios plus
// random traffic, checked against a queue-based reference model and a
// scoreboard of expected display entries.
module tb_wb_trace_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 3;

  typedef struct packed {
    logic [4:0]  d;
    logic [12:0] a;
    logic [12:0] b;
  } ent_t;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        WB_RegWrite = 1'b0;
  logic [4:0]  WB_RegDest = '0;
  logic [31:0] WB_WriteData = '0;
  logic [31:0] WB_PC = '0;
  logic        Freeze = 1'b0;
  logic [12:0] NumberA, NumberB;
  logic [4:0]  Dest_Out;
  logic        Valid_Out, Overflow;
  logic [2:0]  Count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  ent_t mq[$];
  ent_t exp_disp[$];
  ent_t m_last = '0;
  bit   m_show = 0;
  int   m_tmr = 0;
  bit   m_ovf = 0;
  bit   m_live = 0;
  bit   rst_e = 0;
  bit   frz_e = 0;

  wb_trace_buffer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .Clk(clk), .Rst(Rst), .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
    .WB_WriteData(WB_WriteData), .WB_PC(WB_PC), .Freeze(Freeze),
    .NumberA(NumberA), .NumberB(NumberB), .Dest_Out(Dest_Out),
    .Valid_Out(Valid_Out), .Overflow(Overflow), .Count(Count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: advanced once per rising edge from the sampled inputs.
  initial forever begin
    bit   commit, pop;
    ent_t e;
    @(posedge clk);
    rst_e = Rst;
    frz_e = Freeze;
    if (Rst) begin
      mq.delete();
      exp_disp.delete();
      m_last = '0; m_show = 0; m_tmr = 0; m_ovf = 0; m_live = 1;
    end else if (m_live) begin
      commit = WB_RegWrite && !Freeze;
`ifdef WB_TRACE_SKIP_R0_EN
      if (WB_RegDest == 5'd0) commit = 0;
`endif
      pop = 0;
      if (commit && mq.size() == DEPTH) pop = 0;
      if (!Freeze) begin
        if (!m_show || m_tmr == 0) begin
          if (mq.size() > 0) begin
            e = mq.pop_front();
            pop = 1;
            m_last = e;
            exp_disp.push_back(e);
            m_show = 1;
            m_tmr = HOLD - 1;
          end else begin
            m_show = 0;
          end
        end else begin
          m_tmr--;
        end
      end
      if (commit) begin
        if (mq.size() < DEPTH) mq.push_back({WB_RegDest, WB_WriteData[12:0], WB_PC[12:0]});
        else m_ovf = 1;
      end
    end
  end

  // Monitor: per-cycle status checks plus scoreboard check of each new entry.
  initial begin
    int   seen = 0;
    bit   pv = 0;
    bit   is_new;
    ent_t e;
    forever begin
      @(negedge clk);
      if (m_live) begin
        if (rst_e) begin
          seen = 0;
          pv = 0;
        end else begin
          if (Valid_Out) begin
            is_new = !pv || (!frz_e && seen == HOLD);
            if (is_new) begin
              if (exp_disp.size() == 0) begin
                chk("sb_unexpected_entry", 32'(exp_disp.size()), 32'(1));
              end else begin
                e = exp_disp.pop_front();
                chk("sb_dest", 32'(Dest_Out), 32'(e.d));
                chk("sb_numa", 32'(NumberA), 32'(e.a));
                chk("sb_numb", 32'(NumberB), 32'(e.b));
              end
              seen = 1;
            end else if (!frz_e) begin
              seen++;
            end
          end else if (pv) begin
            chk("hold_len", 32'(seen), 32'(HOLD));
          end
          pv = Valid_Out;
        end
        chk("count", 32'(Count), 32'(mq.size()));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
        chk("valid", 32'(Valid_Out), 32'(m_show));
        chk("shown", {8'h0, Dest_Out, NumberA, NumberB}, {8'h0, m_last});
      end
    end
  end

  task automatic cyc(input logic we, input logic [4:0] d, input logic [31:0] wd,
                     input logic [31:0] pc, input logic frz, input logic rst);
    @(negedge clk);
    WB_RegWrite = we; WB_RegDest = d; WB_WriteData = wd; WB_PC = pc;
    Freeze = frz; Rst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held two cycles with commits present
    repeat (2) begin
      cyc(1'b1, 5'd7, 32'hDEAD, 32'h100, 1'b0, 1'b1);
      chk("rst_numa", 32'(NumberA), 32'd0);
      chk("rst_numb", 32'(NumberB), 32'd0);
      chk("rst_dest", 32'(Dest_Out), 32'd0);
      chk("rst_valid", 32'(Valid_Out), 32'd0);
      chk("rst_ovf", 32'(Overflow), 32'd0);
      chk("rst_count", 32'(Count), 32'd0);
    end
    idle(1);
    chk("post_rst_count", 32'(Count), 32'd0);
    chk("post_rst_valid", 32'(Valid_Out), 32'd0);

    // Single commit latency and hold
    cyc(1'b1, 5'd5, 32'h0000_1234, 32'h40, 1'b0, 1'b0);
    chk("single_count", 32'(Count), 32'd1);
    idle(1);
    chk("single_numa", 32'(NumberA), 32'h1234);
    chk("single_numb", 32'(NumberB), 32'h040);
    chk("single_dest", 32'(Dest_Out), 32'd5);
    chk("single_valid", 32'(Valid_Out), 32'd1);
    chk("single_count0", 32'(Count), 32'd0);
    idle(2);
    chk("single_hold_valid", 32'(Valid_Out), 32'd1);
    idle(1);
    chk("single_end_valid", 32'(Valid_Out), 32'd0);
    chk("single_retain", 32'(NumberA), 32'h1234);

    // Burst of 8: write 7 dropped, write 8 accepted alongside a pop
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 5'(i + 1), 32'(i + 1), 32'(4 * i), 1'b0, 1'b0);
      if (i == 5) chk("burst_ovf_e5", 32'(Overflow), 32'd0);
      if (i == 6) chk("burst_ovf_e6", 32'(Overflow), 32'd1);
      if (i == 7) chk("burst_count_e7", 32'(Count), 32'd4);
    end
    idle(30);
    chk("burst_drained", 32'(exp_disp.size()), 32'd0);

    // Freeze mid-show with two entries queued and commits arriving
    cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 5'd1, 32'h11, 32'h10, 1'b0, 1'b0);
    cyc(1'b1, 5'd2, 32'h22, 32'h20, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 32'h33, 32'h30, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 5'(9 + i), 32'h99, 32'h90, 1'b1, 1'b0);
      chk("frz_count", 32'(Count), 32'd2);
      chk("frz_ovf", 32'(Overflow), 32'd0);
      chk("frz_numa", 32'(NumberA), 32'h11);
    end
    idle(20);

    // Reset in the middle of a burst
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 5'(i + 1), 32'(i + 17), 32'(8 * i), 1'b0, (i == 3));
      if (i == 3) begin
        chk("midrst_count", 32'(Count), 32'd0);
        chk("midrst_valid", 32'(Valid_Out), 32'd0);
        chk("midrst_numa", 32'(NumberA), 32'd0);
        chk("midrst_ovf", 32'(Overflow), 32'd0);
      end
      if (i == 5) chk("midrst_reshow", 32'(NumberA), 32'(4 + 17));
    end
    idle(30);

    // Writes to r0 around a write to r3
    cyc(1'b1, 5'd0, 32'hA0, 32'h200, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 32'hA3, 32'h204, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 32'hA8, 32'h208, 1'b0, 1'b0);
    idle(15);
    chk("r0_ovf", 32'(Overflow), 32'd0);
    chk("r0_dest_last", 32'(Dest_Out), 32'(`ifdef WB_TRACE_SKIP_R0_EN 3 `else 0 `endif));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 7), 5'($urandom), $urandom, $urandom,
          ($urandom_range(0, 9) < 1), ($urandom_range(0, 99) < 2));
    end
    idle(40);
    chk("final_sb_empty", 32'(exp_disp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
